// File: rtl/ghost_director.sv
// Ghost behaviour director: WAIT/SCATTER/CHASE/FRIGHT mode sequencing and
// per-tile direction choice (shortest Euclidean distance, or pseudo-random when frightened).
//
// state   | meaning
// WAIT    | level not started; no movement commands
// CHASE   | steer towards the tile under (TargetX, TargetY)
// SCATTER | steer towards the fixed scatter corner tile
// FRIGHT  | random choice at each tile; prior mode's timers frozen
module ghost_director #(
    parameter int SCATTER_TILE_X = 25,
    parameter int SCATTER_TILE_Y = 0,
    parameter int SCATTER_SECS   = 7,
    parameter int CHASE_SECS     = 20,
    parameter int FRIGHT_SECS    = 6,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       game_start,
    input  logic       frighten,
    input  logic [9:0] PosX,
    input  logic [9:0] PosY,
    input  logic [3:0] CurDir,
    input  logic [3:0] avail_dir,
    input  logic [9:0] TargetX,
    input  logic [9:0] TargetY,
    output logic [3:0] next_dir,
    output logic       dir_valid,
    output logic [1:0] ghost_mode
);

    localparam int MAX_SECS = (SCATTER_SECS > CHASE_SECS) ?
                              ((SCATTER_SECS > FRIGHT_SECS) ? SCATTER_SECS : FRIGHT_SECS) :
                              ((CHASE_SECS > FRIGHT_SECS) ? CHASE_SECS : FRIGHT_SECS);
    localparam int FW = $clog2(FRAMES_PER_SEC + 1);
    localparam int SW = $clog2(MAX_SECS + 1);

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        CHASE   = 2'd1,
        SCATTER = 2'd2,
        FRIGHT  = 2'd3
    } mode_t;

    mode_t                 mode;
    mode_t                 saved_mode;
    logic [FW-1:0]         frame_cnt;
    logic [SW-1:0]         sec_cnt;
    logic [FW-1:0]         saved_frame;
    logic [SW-1:0]         saved_sec;
    logic signed [6:0]     last_x;
    logic signed [6:0]     last_y;
    logic                  rev_pending;
    logic [15:0]           lfsr;

    function automatic logic [3:0] rev_dir(input logic [3:0] d);
        case (d)
            4'd1:    return 4'd3;
            4'd2:    return 4'd4;
            4'd3:    return 4'd1;
            4'd4:    return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic signed [6:0] to_tile(input logic [9:0] p);
        return 7'((p / 10'd12) - 10'd6);
    endfunction

    function automatic logic [13:0] dist2(input logic signed [6:0] ax, input logic signed [6:0] ay,
                                          input logic signed [6:0] bx, input logic signed [6:0] by);
        logic signed [8:0]  dx;
        logic signed [8:0]  dy;
        logic signed [17:0] ex;
        logic signed [17:0] ey;
        dx = {{2{ax[6]}}, ax} - {{2{bx[6]}}, bx};
        dy = {{2{ay[6]}}, ay} - {{2{by[6]}}, by};
        ex = {{9{dx[8]}}, dx};
        ey = {{9{dy[8]}}, dy};
        return 14'(ex * ex + ey * ey);
    endfunction

    logic signed [6:0] tile_x, tile_y, tgt_x, tgt_y;
    logic              aligned, do_decide, frame_wrap, expire;
    logic [SW-1:0]     sec_last;
    logic [3:0]        rev, rev_mask, cand, best_dir, rnd_dir, decided;
    logic [13:0]       c_l, c_u, c_r, c_d, best_cost;
    logic              found, rfound;
    logic [1:0]        idx;

    always_comb begin
        tile_x    = to_tile(PosX);
        tile_y    = to_tile(PosY);
        aligned   = ((PosX % 10'd12) == 10'd0) && ((PosY % 10'd12) == 10'd0);
        do_decide = (mode != WAIT) && aligned && !rev_pending &&
                    ((tile_x != last_x) || (tile_y != last_y));

        frame_wrap = (frame_cnt == FW'(FRAMES_PER_SEC - 1));
        case (mode)
            SCATTER: sec_last = SW'(SCATTER_SECS - 1);
            CHASE:   sec_last = SW'(CHASE_SECS - 1);
            FRIGHT:  sec_last = SW'(FRIGHT_SECS - 1);
            default: sec_last = '0;
        endcase
        // expiry fires on the wrap that would make the seconds count reach the limit
        expire = (mode != WAIT) && frame_wrap && (sec_cnt == sec_last);

        rev      = rev_dir(CurDir);
        rev_mask = (rev == 4'd0) ? 4'd0 : (4'b0001 << (rev - 4'd1));
        cand     = avail_dir & ~rev_mask;

        if (mode == CHASE) begin
            tgt_x = to_tile(TargetX);
            tgt_y = to_tile(TargetY);
        end else begin
            tgt_x = 7'(SCATTER_TILE_X);
            tgt_y = 7'(SCATTER_TILE_Y);
        end
        c_l = dist2(tile_x - 7'sd1, tile_y, tgt_x, tgt_y);
        c_u = dist2(tile_x, tile_y - 7'sd1, tgt_x, tgt_y);
        c_r = dist2(tile_x + 7'sd1, tile_y, tgt_x, tgt_y);
        c_d = dist2(tile_x, tile_y + 7'sd1, tgt_x, tgt_y);

        // strict less-than keeps the earlier entry on ties: up, left, down, right
        best_dir  = 4'd0;
        best_cost = '1;
        found     = 1'b0;
        if (cand[1]) begin
            best_dir = 4'd2; best_cost = c_u; found = 1'b1;
        end
        if (cand[0] && (!found || c_l < best_cost)) begin
            best_dir = 4'd1; best_cost = c_l; found = 1'b1;
        end
        if (cand[3] && (!found || c_d < best_cost)) begin
            best_dir = 4'd4; best_cost = c_d; found = 1'b1;
        end
        if (cand[2] && (!found || c_r < best_cost)) begin
            best_dir = 4'd3; best_cost = c_r; found = 1'b1;
        end

        rnd_dir = 4'd0;
        rfound  = 1'b0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = lfsr[1:0] + 2'(k);
            if (!rfound && cand[idx]) begin
                rnd_dir = {2'b00, idx} + 4'd1;
                rfound  = 1'b1;
            end
        end

        if (cand == 4'd0)
            decided = rev;
        else if (mode == FRIGHT)
            decided = rnd_dir;
        else
            decided = best_dir;
    end

    assign ghost_mode = mode;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            mode        <= WAIT;
            saved_mode  <= SCATTER;
            frame_cnt   <= '0;
            sec_cnt     <= '0;
            saved_frame <= '0;
            saved_sec   <= '0;
            last_x      <= 7'h7F;
            last_y      <= 7'h7F;
            rev_pending <= 1'b0;
            lfsr        <= 16'hACE1;
            next_dir    <= 4'd0;
            dir_valid   <= 1'b0;
        end else begin
            lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            dir_valid <= 1'b0;

            if (rev_pending) begin
                next_dir    <= rev;
                dir_valid   <= 1'b1;
                rev_pending <= 1'b0;
            end else if (do_decide) begin
                next_dir  <= decided;
                dir_valid <= 1'b1;
                last_x    <= tile_x;
                last_y    <= tile_y;
            end

            if (mode != WAIT) begin
                if (frame_wrap) begin
                    frame_cnt <= '0;
                    sec_cnt   <= sec_cnt + SW'(1);
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end

            // placed after the reversal consumer so a new request is never lost
            case (mode)
                WAIT: begin
                    if (game_start) begin
                        mode      <= SCATTER;
                        frame_cnt <= '0;
                        sec_cnt   <= '0;
                    end
                end
                CHASE, SCATTER: begin
                    if (frighten) begin
                        mode        <= FRIGHT;
                        saved_mode  <= mode;
                        saved_frame <= frame_cnt;
                        saved_sec   <= sec_cnt;
                        frame_cnt   <= '0;
                        sec_cnt     <= '0;
                        rev_pending <= (CurDir != 4'd0);
                    end else if (expire) begin
                        if (mode == CHASE)
                            mode <= SCATTER;
                        else
                            mode <= CHASE;
                        frame_cnt   <= '0;
                        sec_cnt     <= '0;
                        rev_pending <= (CurDir != 4'd0);
                    end
                end
                FRIGHT: begin
                    if (frighten) begin
                        frame_cnt <= '0;
                        sec_cnt   <= '0;
                    end else if (expire) begin
                        mode      <= saved_mode;
                        frame_cnt <= saved_frame;
                        sec_cnt   <= saved_sec;
                    end
                end
                default: mode <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_director.sv
// Directed bench for ghost_director: mode timing, reversals, tile decisions and reset.
module tb_ghost_director;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       game_start;
    logic       frighten;
    logic [9:0] PosX;
    logic [9:0] PosY;
    logic [3:0] CurDir;
    logic [3:0] avail_dir;
    logic [9:0] TargetX;
    logic [9:0] TargetY;
    logic [3:0] next_dir;
    logic       dir_valid;
    logic [1:0] ghost_mode;

    int n_cmp = 0;
    int n_err = 0;

    ghost_director dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .game_start (game_start),
        .frighten   (frighten),
        .PosX       (PosX),
        .PosY       (PosY),
        .CurDir     (CurDir),
        .avail_dir  (avail_dir),
        .TargetX    (TargetX),
        .TargetY    (TargetY),
        .next_dir   (next_dir),
        .dir_valid  (dir_valid),
        .ghost_mode (ghost_mode)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        Reset = 1'b1; game_start = 1'b0; frighten = 1'b0;
        PosX = 10'd229; PosY = 10'd229; CurDir = 4'd0; avail_dir = 4'd0;
        TargetX = 10'd0; TargetY = 10'd0;
        run(2);
        chk("rst_mode", 16'(ghost_mode), 16'd0);
        chk("rst_next_dir", 16'(next_dir), 16'd0);
        chk("rst_dir_valid", 16'(dir_valid), 16'd0);

        Reset = 1'b0; frighten = 1'b1;
        tick();
        chk("wait_ignores_frighten", 16'(ghost_mode), 16'd0);
        frighten = 1'b0; game_start = 1'b1;
        tick();                                   // E0
        chk("start_to_scatter", 16'(ghost_mode), 16'd2);
        game_start = 1'b0;

        PosX = 10'd228; PosY = 10'd228; CurDir = 4'd1; avail_dir = 4'b0011;
        tick();                                   // E1
        chk("scatter_dec_valid", 16'(dir_valid), 16'd1);
        chk("scatter_dec_dir", 16'(next_dir), 16'd2);
        tick();                                   // E2
        chk("same_tile_no_strobe", 16'(dir_valid), 16'd0);
        chk("next_dir_held", 16'(next_dir), 16'd2);
        tick();                                   // E3
        chk("same_tile_no_strobe2", 16'(dir_valid), 16'd0);

        PosX = 10'd240; CurDir = 4'd3; avail_dir = 4'b0001;
        tick();                                   // E4
        chk("dead_end_valid", 16'(dir_valid), 16'd1);
        chk("dead_end_dir", 16'(next_dir), 16'd1);

        PosX = 10'd241; CurDir = 4'd3;
        run(415);                                 // E419
        chk("scatter_before_expiry", 16'(ghost_mode), 16'd2);
        tick();                                   // E420
        chk("scatter_expiry_to_chase", 16'(ghost_mode), 16'd1);
        chk("no_strobe_on_expiry_edge", 16'(dir_valid), 16'd0);
        tick();                                   // E421
        chk("reverse_valid", 16'(dir_valid), 16'd1);
        chk("reverse_dir", 16'(next_dir), 16'd1);
        tick();                                   // E422
        chk("reverse_one_edge", 16'(dir_valid), 16'd0);

        PosX = 10'd228; PosY = 10'd228; CurDir = 4'd1; avail_dir = 4'b0011;
        TargetX = 10'd192; TargetY = 10'd192;
        tick();                                   // E423, chase count 3
        chk("tie_valid", 16'(dir_valid), 16'd1);
        chk("tie_up_wins", 16'(next_dir), 16'd2);
        PosX = 10'd240; avail_dir = 4'b0111;
        tick();                                   // E424, chase count 4
        chk("chase_left_valid", 16'(dir_valid), 16'd1);
        chk("chase_left_dir", 16'(next_dir), 16'd1);

        PosX = 10'd241; CurDir = 4'd3; avail_dir = 4'b0000;
        run(296);                                 // chase count 300 = 5 s
        frighten = 1'b1;
        tick();                                   // F0
        chk("frighten_enter", 16'(ghost_mode), 16'd3);
        frighten = 1'b0;
        tick();                                   // F1
        chk("fright_rev_valid", 16'(dir_valid), 16'd1);
        chk("fright_rev_dir", 16'(next_dir), 16'd1);

        PosX = 10'd252; PosY = 10'd228; CurDir = 4'd2; avail_dir = 4'b1100;
        tick();                                   // F2
        chk("fright_dec_valid", 16'(dir_valid), 16'd1);
        chk("fright_dec_dir", 16'(next_dir), 16'd3);
        PosX = 10'd253; CurDir = 4'd3; avail_dir = 4'b0000;
        run(357);                                 // F359
        chk("fright_before_return", 16'(ghost_mode), 16'd3);
        tick();                                   // F360 = R
        chk("fright_return_chase", 16'(ghost_mode), 16'd1);
        chk("no_rev_on_return", 16'(dir_valid), 16'd0);
        run(899);                                 // R+899
        chk("chase_restored_count", 16'(ghost_mode), 16'd1);

        frighten = 1'b1;
        tick();                                   // R+900: expiry and frighten together
        chk("frighten_beats_expiry", 16'(ghost_mode), 16'd3);
        frighten = 1'b0;
        tick();                                   // G1
        chk("fright2_rev_valid", 16'(dir_valid), 16'd1);
        run(99);                                  // G100
        frighten = 1'b1;
        tick();                                   // G101 restart
        frighten = 1'b0;
        tick();                                   // G102
        chk("retrigger_no_strobe", 16'(dir_valid), 16'd0);
        chk("retrigger_mode", 16'(ghost_mode), 16'd3);
        run(358);                                 // G460
        chk("retrigger_extends", 16'(ghost_mode), 16'd3);
        tick();                                   // G461
        chk("return_saved_chase", 16'(ghost_mode), 16'd1);
        tick();                                   // G462
        chk("frozen_expiry_to_scatter", 16'(ghost_mode), 16'd2);
        tick();                                   // G463
        chk("chase_scatter_rev_valid", 16'(dir_valid), 16'd1);
        chk("chase_scatter_rev_dir", 16'(next_dir), 16'd1);

        frighten = 1'b1;
        tick();
        chk("fright3_enter", 16'(ghost_mode), 16'd3);
        frighten = 1'b0;
        tick();
        chk("fright3_valid_high", 16'(dir_valid), 16'd1);
        Reset = 1'b1; frighten = 1'b1; game_start = 1'b1;
        tick();
        chk("midfright_rst_mode", 16'(ghost_mode), 16'd0);
        chk("midfright_rst_dir", 16'(next_dir), 16'd0);
        chk("midfright_rst_valid", 16'(dir_valid), 16'd0);
        Reset = 1'b0; frighten = 1'b0; game_start = 1'b0;
        tick();
        chk("post_rst_wait", 16'(ghost_mode), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ghost_director.md
GHOST_DIRECTOR -- requirements
Module: ghost_director

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SCATTER_TILE_X, 25: scatter target tile column.
- SCATTER_TILE_Y, 0: scatter target tile row.
- SCATTER_SECS, 7: scatter duration in seconds.
- CHASE_SECS, 20: chase duration in seconds.
- FRIGHT_SECS, 6: frightened duration in seconds.
- FRAMES_PER_SEC, 60: frames per second.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- frame_clk, in, 1: clock.
- Reset, in, 1: synchronous, active-high reset.
- game_start, in, 1: level started (Pac-Man direction nonzero).
- frighten, in, 1: power-pellet pulse.
- PosX, in, 10: ghost pixel X, top-left.
- PosY, in, 10: ghost pixel Y, top-left.
- CurDir, in, 4: ghost current direction.
- avail_dir, in, 4: legal moves; bit0 left, bit1 up, bit2 right, bit3 down.
- TargetX, in, 10: chase target pixel X.
- TargetY, in, 10: chase target pixel Y.
- next_dir, out, 4: commanded direction.
- dir_valid, out, 1: one-frame strobe, new decision.
- ghost_mode, out, 2: current mode.
REQ-003 Reset SHALL be Reset, synchronous, active-high; clock SHALL be frame_clk.
REQ-004 Direction encoding SHALL be 0 none, 1 left, 2 up, 3 right, 4 down.
REQ-005 Reverse SHALL map 1<->3 and 2<->4; the reverse of 0 SHALL be 0.

Function
REQ-006 Tile coordinate SHALL be pos/12 - 6 (integer divide), held as a signed 7-bit value; X and Y SHALL be computed identically.
REQ-007 "Aligned" SHALL mean PosX%12==0 and PosY%12==0.
REQ-008 Mode FSM states SHALL be WAIT=0, CHASE=1, SCATTER=2, FRIGHT=3.
REQ-009 WAIT SHALL go to SCATTER on the edge where game_start=1.
REQ-010 Frame counter SHALL count 0..FRAMES_PER_SEC-1; the seconds counter SHALL increment on each wrap.
REQ-011 Both counters SHALL clear on every mode entry.
REQ-012 SCATTER SHALL go to CHASE, and CHASE to SCATTER, when the seconds counter equals SCATTER_SECS or CHASE_SECS respectively.
REQ-013 frighten=1 in CHASE or SCATTER SHALL enter FRIGHT, save the prior mode, and freeze the prior mode's counters.
REQ-014 frighten=1 in FRIGHT SHALL restart the FRIGHT count.
REQ-015 frighten=1 in WAIT SHALL be ignored.
REQ-016 FRIGHT SHALL return to the saved mode after FRIGHT_SECS, restoring its frozen counters.
REQ-017 If frighten and a timer expiry occur on the same edge, frighten SHALL win.
REQ-018 On any CHASE<->SCATTER transition, or on entry to FRIGHT, with CurDir!=0, the next edge SHALL drive next_dir = reverse(CurDir) and dir_valid=1, regardless of alignment.
REQ-019 A tile decision SHALL occur on an edge where all of the following hold:
- mode != WAIT;
- the ghost is aligned;
- the current tile differs from the last decided tile;
- no forced reversal is pending.
REQ-020 Candidates SHALL be the avail_dir bits excluding reverse(CurDir); with no candidates, the result SHALL be reverse(CurDir).
REQ-021 The CHASE target SHALL be the tile of (TargetX, TargetY); the SCATTER target SHALL be (SCATTER_TILE_X, SCATTER_TILE_Y).
REQ-022 Cost SHALL be dx^2 + dy^2 from the neighbour tile in the candidate direction to the target, as 14-bit unsigned; the minimum cost SHALL win.
REQ-023 Ties SHALL resolve in priority up, left, down, right.
REQ-024 In FRIGHT, the start direction SHALL be lfsr[1:0]+1; the result SHALL be the first candidate found rotating 1->2->3->4->1 from it.
REQ-025 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, and SHALL step every edge.
REQ-026 next_dir and dir_valid SHALL register on the decision edge; next_dir SHALL hold until the next decision.
REQ-027 dir_valid SHALL be 1 for exactly one edge per decision.
REQ-028 The last decided tile SHALL update on each decision, so one tile SHALL yield one decision.
REQ-029 next_dir SHALL be 0 while in WAIT.
REQ-030 Tunnel wrap SHALL need no special handling; any tile change SHALL re-arm decisions.

Reset
REQ-031 Reset SHALL set the following:
- ghost_mode=0, next_dir=0, dir_valid=0;
- all counters 0;
- saved mode=SCATTER;
- last-decided tile = 7'h7F (invalid);
- pending reversal cleared;
- LFSR=16'hACE1.
REQ-032 Reset SHALL take priority over game_start, frighten, and decisions on the same edge.
REQ-033 Reset mid-FRIGHT or mid-decision SHALL leave no residual state.

Verification
REQ-034 Scenario: Reset, then game_start=1 -> ghost_mode=2 next edge; exactly 420 edges later, ghost_mode=1 and next_dir=reverse(CurDir) with dir_valid=1 one edge after that.
REQ-035 Scenario: SCATTER, PosX=PosY=228 (tile 13,13), CurDir=1, avail_dir=4'b0011 -> next_dir=2 (cost up 288 < left 338), dir_valid=1 for one edge; holding position gives no further strobe.
REQ-036 Scenario: dead end, CurDir=3, avail_dir=4'b0001 -> next_dir=1.
REQ-037 Scenario: tie, CHASE with Target tile straight ahead diagonally, equal up/left costs -> next_dir=2.
REQ-038 Scenario: CHASE at second 5, frighten -> mode 3, reversal issued; after 360 edges -> mode 1, and CHASE expires 15 s later (counters restored).
REQ-039 Scenario: Reset asserted in FRIGHT with dir_valid high -> next edge: mode 0, next_dir 0, dir_valid 0, LFSR=16'hACE1.
